load_store_unit: RTL and testbench

Initiator side of the data-memory port. Accepts one load or store request at a time from the execute/memory stage and drives the word-wide data memory (`A`, `WD`, `WE`, `RD`). That memory has combinational read, a registered write on `posedge clk`, word index `A[31:2]`, and no byte enables. The unit performs RV32I sub-word extraction, sign/zero extension, and read-modify-write for SB/SH, then returns a single response per request over a valid/ready handshake.

---
 rtl/load_store_unit.sv | 234 +++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store initiator for a word-wide data memory: RV32I sub-word extract/extend and SB/SH read-modify-write.
// Optional build macro LSU_MISALIGN_TRAP_EN turns misaligned LH/LHU/SH/LW/SW into error responses.
module load_store_unit #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  input  logic [31:0] mem_RD
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_MERGE  = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

  function automatic logic funct3_illegal(input logic we, input logic [2:0] f3);
    logic bad;
    if (we) begin
      case (f3)
        3'd0, 3'd1, 3'd2: bad = 1'b0;
        default:          bad = 1'b1;
      endcase
    end else begin
      case (f3)
        3'd0, 3'd1, 3'd2, 3'd4, 3'd5: bad = 1'b0;
        default:                      bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3[1:0])
      2'd1:    mis = off[0];
      2'd2:    mis = (off != 2'd0);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction
`endif

  // Low address bits below the access size are ignored: a half uses lane off[1].
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                               input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    if (off[1]) begin
      h = word[31:16];
    end else begin
      h = word[15:0];
    end
    case (f3)
      3'd0:    r = {{24{b[7]}}, b};
      3'd1:    r = {{16{h[15]}}, h};
      3'd2:    r = word;
      3'd4:    r = {24'd0, b};
      3'd5:    r = {16'd0, h};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] off,
                                              input logic [2:0] f3, input logic [31:0] wdata);
    logic [31:0] m;
    m = word;
    case (f3)
      3'd0: m[{off, 3'b000} +: 8] = wdata[7:0];
      3'd1: begin
        if (off[1]) begin
          m[31:16] = wdata[15:0];
        end else begin
          m[15:0] = wdata[15:0];
        end
      end
      default: m = wdata;
    endcase
    return m;
  endfunction

  state_t      state_r, state_s;
  logic        we_r, we_s;
  logic [2:0]  funct3_r, funct3_s;
  logic [31:0] addr_r, addr_s;
  logic [31:0] wdata_r, wdata_s;
  logic        resp_valid_r, resp_valid_s;
  logic [31:0] resp_rdata_r, resp_rdata_s;
  logic        resp_err_r, resp_err_s;
  logic [31:0] mem_a_r, mem_a_s;
  logic [31:0] mem_wd_r, mem_wd_s;
  logic        mem_we_r, mem_we_s;
  logic        mis_err_s;
  logic        req_err_s;

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_err_s = misaligned(req_funct3, req_addr[1:0]);
`else
  assign mis_err_s = 1'b0;
`endif

  assign req_err_s = funct3_illegal(req_we, req_funct3) || (req_addr >= MEM_BYTES) || mis_err_s;

  // Next-state and next-output computation; memory-port outputs are registered from here.
  always_comb begin
    state_s      = state_r;
    we_s         = we_r;
    funct3_s     = funct3_r;
    addr_s       = addr_r;
    wdata_s      = wdata_r;
    resp_rdata_s = resp_rdata_r;
    resp_err_s   = resp_err_r;
    mem_a_s      = 32'd0;
    mem_wd_s     = 32'd0;
    mem_we_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          we_s         = req_we;
          funct3_s     = req_funct3;
          addr_s       = req_addr;
          wdata_s      = req_wdata;
          resp_rdata_s = 32'd0;
          if (req_err_s) begin
            resp_err_s = 1'b1;
            state_s    = ST_RESP;
          end else begin
            resp_err_s = 1'b0;
            state_s    = ST_ACCESS;
            mem_a_s    = {req_addr[31:2], 2'b00};
            // SW writes during ACCESS itself, so its strobe is loaded at accept.
            if (req_we && (req_funct3 == 3'd2)) begin
              mem_we_s = 1'b1;
              mem_wd_s = req_wdata;
            end else begin
              mem_we_s = 1'b0;
              mem_wd_s = 32'd0;
            end
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (we_r) begin
          if (funct3_r == 3'd2) begin
            state_s = ST_RESP;
          end else begin
            mem_a_s  = mem_a_r;
            mem_wd_s = store_merge(mem_RD, addr_r[1:0], funct3_r, wdata_r);
            mem_we_s = 1'b1;
            state_s  = ST_MERGE;
          end
        end else begin
          resp_rdata_s = load_extract(mem_RD, addr_r[1:0], funct3_r);
          state_s      = ST_RESP;
        end
      end
      ST_MERGE: begin
        state_s = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  assign resp_valid_s = (state_s == ST_RESP);

  // State, latched request and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      we_r         <= 1'b0;
      funct3_r     <= 3'd0;
      addr_r       <= 32'd0;
      wdata_r      <= 32'd0;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'd0;
      resp_err_r   <= 1'b0;
      mem_a_r      <= 32'd0;
      mem_wd_r     <= 32'd0;
      mem_we_r     <= 1'b0;
    end else begin
      state_r      <= state_s;
      we_r         <= we_s;
      funct3_r     <= funct3_s;
      addr_r       <= addr_s;
      wdata_r      <= wdata_s;
      resp_valid_r <= resp_valid_s;
      resp_rdata_r <= resp_rdata_s;
      resp_err_r   <= resp_err_s;
      mem_a_r      <= mem_a_s;
      mem_wd_r     <= mem_wd_s;
      mem_we_r     <= mem_we_s;
    end
  end

  assign req_ready  = (state_r == ST_IDLE);
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;
  assign mem_A      = mem_a_r;
  assign mem_WD     = mem_wd_r;
  assign mem_WE     = mem_we_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 64-word memory model (combinational read, posedge write).
module tb_load_store_unit;
  localparam int MEM_WORDS = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;

  logic [31:0] mem [0:MEM_WORDS-1];
  int checks = 0;
  int errors = 0;
  int we_cnt = 0;

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (mem_A[31:8] == 24'd0) mem_RD = mem[mem_A[7:2]];
    else mem_RD = 32'd0;
  end

  always @(posedge clk) begin
    if (mem_WE && (mem_A[31:8] == 24'd0)) mem[mem_A[7:2]] <= mem_WD;
    if (mem_WE) we_cnt <= we_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One request: accept, check address, latency, payload, optional hold, handshake, write count.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_wes, input int hold);
    int lat;
    int base;
    @(negedge clk);
    chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
    base = we_cnt;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    if (!exp_err) chk({tag, " mem_A"}, mem_A, {addr[31:2], 2'b00});
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " rdata"}, resp_rdata, exp_rdata);
    chk({tag, " err"}, 32'(resp_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, " held valid"}, 32'(resp_valid), 32'd1);
      chk({tag, " held req_ready"}, 32'(req_ready), 32'd0);
      chk({tag, " held rdata"}, resp_rdata, exp_rdata);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, " valid dropped"}, 32'(resp_valid), 32'd0);
    chk({tag, " write cycles"}, 32'(we_cnt - base), 32'(exp_wes));
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'd0;
    mem[5]     = 32'h11223344;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'd0);
    chk("rst resp_err", 32'(resp_err), 32'd0);
    chk("rst mem_WE", 32'(mem_WE), 32'd0);
    chk("rst mem_A", mem_A, 32'd0);
    chk("rst mem_WD", mem_WD, 32'd0);
    rst = 1'b0;

    do_req("sw10",  1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1, 0);
    do_req("lw10",  1'b0, 3'd2, 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0, 0, 0);
    do_req("lb13",  1'b0, 3'd0, 32'h13, 32'h0, 2, 32'hFFFFFFDE, 1'b0, 0, 0);
    do_req("lbu13", 1'b0, 3'd4, 32'h13, 32'h0, 2, 32'h000000DE, 1'b0, 0, 0);
    do_req("lh10",  1'b0, 3'd1, 32'h10, 32'h0, 2, 32'hFFFFBEEF, 1'b0, 0, 0);
    do_req("lhu12", 1'b0, 3'd5, 32'h12, 32'h0, 2, 32'h0000DEAD, 1'b0, 0, 0);
    do_req("lb10",  1'b0, 3'd0, 32'h10, 32'h0, 2, 32'hFFFFFFEF, 1'b0, 0, 0);

    do_req("sb11",  1'b1, 3'd0, 32'h11, 32'hAAAAAA55, 3, 32'h0, 1'b0, 1, 0);
    do_req("lw sb", 1'b0, 3'd2, 32'h10, 32'h0, 2, 32'hDEAD55EF, 1'b0, 0, 0);
    do_req("sh12",  1'b1, 3'd1, 32'h12, 32'hFFFF1234, 3, 32'h0, 1'b0, 1, 0);
    do_req("lw sh", 1'b0, 3'd2, 32'h10, 32'h0, 2, 32'h123455EF, 1'b0, 0, 0);

    do_req("lw oor",   1'b0, 3'd2, 32'h100, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    do_req("sw oor",   1'b1, 3'd2, 32'h100, 32'h5A5A5A5A, 1, 32'h0, 1'b1, 0, 0);
    do_req("ld f3=3",  1'b0, 3'd3, 32'h10, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    do_req("st f3=4",  1'b1, 3'd4, 32'h10, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    do_req("lw last",  1'b0, 3'd2, 32'hFC, 32'h0, 2, 32'h0, 1'b0, 0, 0);

`ifdef LSU_MISALIGN_TRAP_EN
    do_req("lh11", 1'b0, 3'd1, 32'h11, 32'h0, 1, 32'h0, 1'b1, 0, 0);
`else
    // Half lane 0 of 0x123455EF is 0x55EF, positive, so sign extension yields 0x000055EF.
    do_req("lh11", 1'b0, 3'd1, 32'h11, 32'h0, 2, 32'h000055EF, 1'b0, 0, 0);
`endif
    do_req("lh12", 1'b0, 3'd1, 32'h12, 32'h0, 2, 32'h00001234, 1'b0, 0, 0);

    do_req("hold", 1'b0, 3'd2, 32'h10, 32'h0, 2, 32'h123455EF, 1'b0, 0, 5);

    // Reset during the read phase of an SB must leave memory untouched.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'd0;
    req_addr   = 32'h14;
    req_wdata  = 32'h000000AB;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rmw access WE", 32'(mem_WE), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rmw rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rmw rst mem_WE", 32'(mem_WE), 32'd0);
    chk("rmw rst mem_A", mem_A, 32'd0);
    chk("rmw rst mem_WD", mem_WD, 32'd0);
    chk("rmw rst resp_err", 32'(resp_err), 32'd0);
    chk("rmw rst req_ready", 32'(req_ready), 32'd1);
    chk("rmw mem word", mem[5], 32'h11223344);
    rst = 1'b0;
    do_req("lw14", 1'b0, 3'd2, 32'h14, 32'h0, 2, 32'h11223344, 1'b0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

endmodule
